// File: rtl/sha256_pkg.sv
// Shared SHA-256 front-end definitions: block geometry, padding constant and padder FSM states.
package sha256_pkg;

   localparam int unsigned BLOCK_WORDS = 16;
   localparam int unsigned WORD_BITS   = 32;
   localparam int unsigned BLOCK_BITS  = BLOCK_WORDS * WORD_BITS;

   localparam logic [WORD_BITS-1:0] PAD_WORD = 32'h8000_0000;

   typedef enum logic [1:0] {
      FILL,
      PAD,
      EMIT
   } padder_state_t;

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Word-stream input and 512-bit block output of the SHA-256 message padder.
interface sha256_msg_padder_if;

   logic [sha256_pkg::WORD_BITS-1:0]  in_data;
   logic                              in_valid;
   logic                              in_last;
   logic [1:0]                        in_bytes;
   logic                              in_ready;
   logic                              blk_ready;
   logic [sha256_pkg::BLOCK_BITS-1:0] M;
   logic                              M_valid;
   logic                              M_first;
   logic                              M_final;

   modport master (
      output in_data, in_valid, in_last, in_bytes, blk_ready,
      input  in_ready, M, M_valid, M_first, M_final
   );

   modport slave (
      input  in_data, in_valid, in_last, in_bytes, blk_ready,
      output in_ready, M, M_valid, M_first, M_final
   );

endinterface

// File: rtl/sha256_last_word.sv
// Closing-word formatter: keeps the left-justified valid bytes, inserts 0x80 after them
// and zeroes the remaining (garbage) bytes; reports the valid byte count (0 encodes 4).
module sha256_last_word
   import sha256_pkg::*;
(
   input  logic [WORD_BITS-1:0] data,
   input  logic [1:0]           bytes,
   output logic [WORD_BITS-1:0] word,
   output logic [2:0]           nbytes
);

   always_comb begin
      word   = data;
      nbytes = 3'd4;
      case (bytes)
         2'd1: begin
            word   = {data[31:24], 8'h80, 16'h0000};
            nbytes = 3'd1;
         end
         2'd2: begin
            word   = {data[31:16], 8'h80, 8'h00};
            nbytes = 3'd2;
         end
         2'd3: begin
            word   = {data[31:8], 8'h80};
            nbytes = 3'd3;
         end
         default: begin
            word   = data;
            nbytes = 3'd4;
         end
      endcase
   end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a 32-bit word stream into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit bit length.
module sha256_msg_padder
   import sha256_pkg::*;
#(
   parameter int unsigned LEN_BITS = 64
) (
   input  logic               clk,
   input  logic               rst,
   sha256_msg_padder_if.slave bus
);

   localparam int unsigned IDX_W      = 5;
   localparam int unsigned LEN_HI_IDX = 14;
   localparam int unsigned LEN_LO_IDX = 15;

   padder_state_t       state;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    idx_inc;
   logic [LEN_BITS-1:0] len;
   logic [63:0]         len64;
   logic                pad_done;
   logic                first_pend;
   logic                final_pend;
   logic                last_seen;
   logic                spill;
   logic [WORD_BITS-1:0] blk_buf [BLOCK_WORDS];

   logic [WORD_BITS-1:0] lw_word;
   logic [2:0]           lw_nbytes;
   logic [2:0]           acc_nbytes;
   logic [WORD_BITS-1:0] fill_word;
   logic [WORD_BITS-1:0] pad_word;

   sha256_last_word u_last_word (
      .data   (bus.in_data),
      .bytes  (bus.in_bytes),
      .word   (lw_word),
      .nbytes (lw_nbytes)
   );

   assign idx_inc    = idx + IDX_W'(1);
   assign len64      = 64'(len);
   assign acc_nbytes = bus.in_last ? lw_nbytes : 3'd4;
   assign fill_word  = bus.in_last ? lw_word : bus.in_data;

   // Padding word for the current slot; a spilled marker forces zeros until the next block.
   always_comb begin
      pad_word = '0;
      if (!pad_done) begin
         pad_word = PAD_WORD;
      end else if (spill) begin
         pad_word = '0;
      end else if (idx == IDX_W'(LEN_HI_IDX)) begin
         pad_word = len64[63:32];
      end else if (idx == IDX_W'(LEN_LO_IDX)) begin
         pad_word = len64[31:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FILL;
         idx        <= '0;
         len        <= '0;
         pad_done   <= 1'b0;
         first_pend <= 1'b1;
         final_pend <= 1'b0;
         last_seen  <= 1'b0;
         spill      <= 1'b0;
         for (int i = 0; i < int'(BLOCK_WORDS); i++) begin
            blk_buf[i] <= '0;
         end
      end else begin
         case (state)
            FILL: begin
               if (bus.in_valid) begin
                  blk_buf[idx[3:0]] <= fill_word;
                  idx               <= idx_inc;
                  len               <= len + LEN_BITS'({acc_nbytes, 3'b000});
                  if (bus.in_last) begin
                     last_seen <= 1'b1;
                     if (lw_nbytes != 3'd4) begin
                        pad_done <= 1'b1;
                        // No room left for the 64-bit length behind the marker.
                        if (idx_inc > IDX_W'(LEN_HI_IDX)) begin
                           spill <= 1'b1;
                        end
                     end
                  end
                  if (idx_inc == IDX_W'(BLOCK_WORDS)) begin
                     state <= EMIT;
                  end else if (bus.in_last) begin
                     state <= PAD;
                  end
               end
            end

            PAD: begin
               blk_buf[idx[3:0]] <= pad_word;
               idx               <= idx_inc;
               if (!pad_done) begin
                  pad_done <= 1'b1;
                  if (idx_inc > IDX_W'(LEN_HI_IDX)) begin
                     spill <= 1'b1;
                  end
               end else if (!spill && idx == IDX_W'(LEN_LO_IDX)) begin
                  final_pend <= 1'b1;
               end
               if (idx_inc == IDX_W'(BLOCK_WORDS)) begin
                  state <= EMIT;
               end
            end

            EMIT: begin
               if (bus.blk_ready) begin
                  idx        <= '0;
                  spill      <= 1'b0;
                  first_pend <= final_pend;
                  if (final_pend) begin
                     len        <= '0;
                     pad_done   <= 1'b0;
                     final_pend <= 1'b0;
                     last_seen  <= 1'b0;
                     state      <= FILL;
                  end else if (last_seen) begin
                     state <= PAD;
                  end else begin
                     state <= FILL;
                  end
               end
            end

            default: state <= FILL;
         endcase
      end
   end

   assign bus.in_ready = (state == FILL);
   assign bus.M_valid  = (state == EMIT) && bus.blk_ready;
   assign bus.M_first  = (state == EMIT) && first_pend;
   assign bus.M_final  = (state == EMIT) && final_pend;

   for (genvar g = 0; g < int'(BLOCK_WORDS); g++) begin : g_block_out
      assign bus.M[BLOCK_BITS-1-WORD_BITS*g -: WORD_BITS] = blk_buf[g];
   end

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Upstream feeder for the SHA-256 message schedule. It accepts a big-endian 32-bit word stream with a valid/ready handshake and assembles 512-bit message blocks. It applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit bit-length. Each completed block is presented on `M` with a one-cycle `M_valid` load pulse, the form the schedule's 16-word shift register loads directly.

## Interface
- `LEN_BITS`, default 64: width of the message bit-length counter. Must be 64 for SHA-256. The length is the low 64 bits of the byte count × 8.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_data`  in  32: message word. The first byte is in [31:24].
- `in_valid`  in  1: `in_data` is valid.
- `in_last`  in  1: this word ends the message.
- `in_bytes`  in  2: valid bytes in the last word, left-justified. 1, 2 or 3 give that count; 0 means 4. Ignored unless `in_last`.
- `in_ready`  out  1: the padder accepts a word this cycle.
- `blk_ready`  in  1: downstream can take a block this cycle.
- `M`  out  512: block. Word 0 is at [511:480]; word 15 is at [31:0].
- `M_valid`  out  1: one-cycle load pulse. `M` is valid while this is high.
- `M_first`  out  1: block is the first of its message. Qualified by `M_valid`.
- `M_final`  out  1: block is the last of its message. Qualified by `M_valid`.

## Operation
- State: 16×32 buffer, 5-bit index `idx` (0..16), 64-bit `len`, flags `pad_done`, `first_pend`, `final_pend`.
- FSM states: FILL, PAD, EMIT.
- FILL
  - `in_ready` = 1 in FILL only.
  - On each handshake, write the word to `buf[idx]`, increment `idx`, and add 8×(valid bytes) to `len`.
  - Last word with 1–3 bytes: bytes are kept, 0x80 goes in byte position n, lower bytes are zeroed (input garbage is masked), and `pad_done` is set.
  - Last word with 4 bytes: `pad_done` stays clear.
  - After the last word, go to PAD.
  - If `idx` reaches 16, go to EMIT.
- PAD: writes one word per cycle at `idx`.
  - If `!pad_done`: write 0x80000000 and set `pad_done`.
  - Else if `idx`==14: write `len[63:32]`.
  - Else if `idx`==15: write `len[31:0]` and set `final_pend`.
  - Else: write 0.
  - When `idx` reaches 16, go to EMIT.
- Extra block: if `pad_done` is set with `idx`>14, the block is emitted, `idx` restarts at 0, and PAD continues. The zeros and length then go in the extra block.
- EMIT
  - `M` is driven from the buffer and is stable throughout EMIT.
  - `M_valid` = `blk_ready`.
  - On `M_valid`: clear `idx`.
    - If `final_pend`: clear `len`, `pad_done` and `final_pend`; set `first_pend`; go to FILL.
    - Else if the message is still padding: go to PAD.
    - Else: go to FILL.
  - `M_first` = `first_pend`, which clears on `M_valid`.
  - `M_final` = `final_pend`.
- Empty messages are not supported.
- `len` wraps modulo 2^64 with no error.

## Timing
- Reset values: FILL, `idx`=0, `len`=0, `pad_done`=0, `final_pend`=0, `first_pend`=1.
  - Outputs: `M`=0, `M_valid`=0, `M_first`=0, `M_final`=0.
  - `in_ready`=1 after reset deasserts.
- Reset asserted mid-message discards the partial block and length. No `M_valid` is issued for it.
- `in_ready` is a registered-state decode with no combinational path from `in_valid`.
- Latency: the block completes k cycles after the handshake that wrote word 16−k, with one word per cycle in PAD.
  - EMIT is entered on the cycle after `idx` reaches 16.
  - `M_valid` comes at the earliest in the first EMIT cycle.
- Back-to-back: a full block of data followed by `blk_ready`=1 gives 17 cycles per block. That is 16 fill cycles plus 1 EMIT cycle; `in_ready` is 0 in EMIT.
- `blk_ready` low holds EMIT indefinitely. `M` must stay constant and `in_ready` must stay 0.
- `in_valid` dropping mid-message is legal. `idx` and `len` hold.

## Structure
- Shared `sha256_pkg`:
  - `BLOCK_WORDS`=16
  - `PAD_WORD`=32'h80000000
  - FSM state enum `padder_state_t` {FILL, PAD, EMIT}
- One sub-module, `sha256_last_word`: combinational. It takes `in_data` and `in_bytes` and returns the masked word with the 0x80 byte inserted, plus the byte count.
- The top level holds the FSM, buffer, index and length counter.

## Test plan
- "abc" as one word 0x61626300 with `in_last`, `in_bytes`=3:
  - Expect one block, word0=0x61626380, words1–14=0, word15=0x00000018.
  - `M_first`=`M_final`=1.
- 55 bytes (14 words, last `in_bytes`=3):
  - Expect one block, word13 ending in 0x80, word14=0, word15=0x000001B8.
- 56 bytes (14 full words):
  - Block 1 has data, word14=0x80000000, word15=0. `M_first`=1, `M_final`=0.
  - Block 2 is all zeros except word15=0x000001C0. `M_final`=1.
- 64 bytes (16 full words):
  - Block 1 is data only.
  - Block 2 has word0=0x80000000 and word15=0x00000200.
- Backpressure: hold `blk_ready`=0 for 10 cycles in EMIT.
  - `M` is unchanged, `M_valid`=0 and `in_ready`=0 throughout.
  - A single `M_valid` follows `blk_ready` rising.
- Reset mid-message: assert `rst` after 5 words, then send "abc".
  - Expect exactly one block, identical to the first scenario, with `M_first`=1.
